// File: rtl/mem_access_sequencer_if.sv
// Decoder <-> memory access sequencer bundle: start/op request, MFC return, and the
// memory-side strobes. The master drives requests and MFC; the sequencer is the slave.
interface mem_access_sequencer_if #(
  parameter int OPW = 6
);
  logic           start;
  logic [1:0]     op;
  logic [OPW-1:0] op3_in;
  logic           MFC;
  logic           MAR_Enable;
  logic           MDR_Enable;
  logic           MDR_Mux_select;
  logic           RAM_enable;
  logic [OPW-1:0] RAM_OpCode;
  logic           TEMP_Enable;
  logic           register_file;
  logic           wb_src_temp;
  logic           busy;
  logic           done;
  logic           error;

  modport master (
    output start, op, op3_in, MFC,
    input  MAR_Enable, MDR_Enable, MDR_Mux_select, RAM_enable, RAM_OpCode,
           TEMP_Enable, register_file, wb_src_temp, busy, done, error
  );

  modport slave (
    input  start, op, op3_in, MFC,
    output MAR_Enable, MDR_Enable, MDR_Mux_select, RAM_enable, RAM_OpCode,
           TEMP_Enable, register_file, wb_src_temp, busy, done, error
  );
endinterface

// File: rtl/mem_access_sequencer.sv
// Load/store/swap strobe sequencer; done 5/4/8 cycles after accept plus MFC waits, start ignored while busy.
// Registered Moore outputs; MEM_TIMEOUT_EN adds an MFC watchdog (ERR state, error pulse).
module mem_access_sequencer #(
  parameter int OPW            = 6,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  Clk,
  input  logic                  RESET,
  mem_access_sequencer_if.slave bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_LD_REQ, S_LD_CAP, S_WB, S_SW_TEMP,
    S_ST_DATA, S_ST_REQ, S_SW_WB, S_DONE, S_ERR
  } state_t;

  localparam logic [1:0] OP_LD  = 2'b00;
  localparam logic [1:0] OP_ST  = 2'b01;
  localparam logic [1:0] OP_SW  = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  state_t         state_q, state_d;
  logic [1:0]     op_q, op_d;
  logic [OPW-1:0] op3_q, op3_d;

  logic           mar_q, mdr_en_q, mdr_mux_q, ram_en_q, temp_q, rf_q, wb_temp_q, busy_q, done_q;
  logic [OPW-1:0] opc_q;

`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] tmo_q, tmo_d;
  logic          tmo_hit;
  logic          error_q;

  // MFC on the limiting edge takes the normal path, hence the !MFC term.
  assign tmo_hit = !bus.MFC && (tmo_q == CW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_CYCLES != 0);
`endif

  // Swap reads with a word-load opcode, then writes back with a word-store opcode.
  function automatic logic [OPW-1:0] opc_for(state_t s, logic [1:0] o, logic [OPW-1:0] o3);
    logic [OPW-1:0] r;
    r = '0;
    if (s != S_IDLE && s != S_ERR) begin
      if (o != OP_SW) r = o3;
      else if (s == S_ST_DATA || s == S_ST_REQ || s == S_SW_WB || s == S_DONE) r = OPW'(4);
    end
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    op3_d   = op3_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start && bus.op != OP_RSV) begin
          op_d    = bus.op;
          op3_d   = bus.op3_in;
          state_d = S_ADDR;
        end
      end
      S_ADDR:    state_d = (op_q == OP_ST) ? S_ST_DATA : S_LD_REQ;
      S_LD_REQ: begin
        if (bus.MFC) state_d = S_LD_CAP;
`ifdef MEM_TIMEOUT_EN
        else if (tmo_hit) state_d = S_ERR;
`endif
      end
      S_LD_CAP:  state_d = (op_q == OP_LD) ? S_WB : S_SW_TEMP;
      S_WB:      state_d = S_DONE;
      S_SW_TEMP: state_d = S_ST_DATA;
      S_ST_DATA: state_d = S_ST_REQ;
      S_ST_REQ: begin
        if (bus.MFC) state_d = (op_q == OP_SW) ? S_SW_WB : S_DONE;
`ifdef MEM_TIMEOUT_EN
        else if (tmo_hit) state_d = S_ERR;
`endif
      end
      S_SW_WB:   state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      S_ERR:     state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  // Staying in a request state implies MFC was low; any entry restarts from zero.
  always_comb begin
    tmo_d = '0;
    if ((state_q == S_LD_REQ || state_q == S_ST_REQ) && state_d == state_q)
      tmo_d = tmo_q + CW'(1);
  end
`endif

  always_ff @(posedge Clk or posedge RESET) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      op3_q     <= '0;
      mar_q     <= 1'b0;
      mdr_en_q  <= 1'b0;
      mdr_mux_q <= 1'b0;
      ram_en_q  <= 1'b0;
      temp_q    <= 1'b0;
      rf_q      <= 1'b0;
      wb_temp_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      opc_q     <= '0;
`ifdef MEM_TIMEOUT_EN
      tmo_q     <= '0;
      error_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      op3_q     <= op3_d;
      mar_q     <= (state_d == S_ADDR);
      mdr_en_q  <= (state_d == S_LD_CAP) || (state_d == S_ST_DATA);
      mdr_mux_q <= (state_d == S_LD_REQ) || (state_d == S_LD_CAP);
      ram_en_q  <= (state_d == S_LD_REQ) || (state_d == S_ST_REQ);
      temp_q    <= (state_d == S_SW_TEMP);
      rf_q      <= (state_d == S_WB) || (state_d == S_SW_WB);
      wb_temp_q <= (state_d == S_SW_WB);
      busy_q    <= (state_d != S_IDLE);
      done_q    <= (state_d == S_DONE);
      opc_q     <= opc_for(state_d, op_d, op3_d);
`ifdef MEM_TIMEOUT_EN
      tmo_q     <= tmo_d;
      error_q   <= (state_d == S_ERR);
`endif
    end
  end

  assign bus.MAR_Enable     = mar_q;
  assign bus.MDR_Enable     = mdr_en_q;
  assign bus.MDR_Mux_select = mdr_mux_q;
  assign bus.RAM_enable     = ram_en_q;
  assign bus.RAM_OpCode     = opc_q;
  assign bus.TEMP_Enable    = temp_q;
  assign bus.register_file  = rf_q;
  assign bus.wb_src_temp    = wb_temp_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
`ifdef MEM_TIMEOUT_EN
  assign bus.error          = error_q;
`else
  assign bus.error          = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Bench for mem_access_sequencer: per-cycle expected strobe traces built from each access's phase list.
module tb_mem_access_sequencer;
  localparam int OPW = 6;
  localparam int TMO = 4;

  logic Clk = 1'b0;
  logic RESET = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [15:0] exp_q[$];
  logic        mfc_q[$];
  logic [15:0] obs_v;

  mem_access_sequencer_if #(.OPW(OPW)) bus();

  mem_access_sequencer #(.OPW(OPW), .TIMEOUT_CYCLES(TMO)) dut (
    .Clk   (Clk),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  assign obs_v = {bus.MAR_Enable, bus.MDR_Enable, bus.MDR_Mux_select, bus.RAM_enable,
                  bus.RAM_OpCode, bus.TEMP_Enable, bus.register_file, bus.wb_src_temp,
                  bus.busy, bus.done, bus.error};

  function automatic logic [15:0] v(logic mar, logic mdr, logic mux, logic ram, logic [5:0] opc,
                                    logic tmp, logic rf, logic wbt, logic bsy, logic dn, logic err);
    return {mar, mdr, mux, ram, opc, tmp, rf, wbt, bsy, dn, err};
  endfunction

  function automatic logic rbit();
    return logic'($urandom_range(0, 1));
  endfunction

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] expv);
    checks++;
    assert (got === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, expv);
    end
  endtask

  task automatic push(input logic [15:0] e, input logic m);
    exp_q.push_back(e);
    mfc_q.push_back(m);
  endtask

  // Expected trace: one idle cycle carrying the start, the access phases, then one idle cycle.
  // d1/d2 = extra MFC-low cycles in the read and write request phases.
  task automatic build(input logic [1:0] op, input logic [5:0] op3, input int d1, input int d2);
    logic [5:0] a_opc, s_opc;
    a_opc = (op == 2'd2) ? 6'd0 : op3;
    s_opc = (op == 2'd2) ? 6'd4 : op3;
    push('0, rbit());
    push(v(1,0,0,0,a_opc,0,0,0,1,0,0), rbit());
    if (op != 2'd1) begin
      for (int j = 0; j <= d1; j++) push(v(0,0,1,1,a_opc,0,0,0,1,0,0), (j == d1));
      push(v(0,1,1,0,a_opc,0,0,0,1,0,0), rbit());
      if (op == 2'd0) push(v(0,0,0,0,a_opc,0,1,0,1,0,0), rbit());
      else            push(v(0,0,0,0,a_opc,1,0,0,1,0,0), rbit());
    end
    if (op != 2'd0) begin
      push(v(0,1,0,0,s_opc,0,0,0,1,0,0), rbit());
      for (int j = 0; j <= d2; j++) push(v(0,0,0,1,s_opc,0,0,0,1,0,0), (j == d2));
      if (op == 2'd2) push(v(0,0,0,0,s_opc,0,1,1,1,0,0), rbit());
    end
    push(v(0,0,0,0,s_opc,0,0,0,1,1,0), rbit());
    push('0, rbit());
  endtask

  // Replays the trace: check the cycle's outputs, then drive that cycle's inputs.
  // Busy cycles get random start/op noise; trailing idle gets only reserved-op starts.
  task automatic run(input logic [1:0] rop, input logic [5:0] rop3, input int n, input string tag);
    int cyc;
    cyc = (n < 0 || n > exp_q.size()) ? exp_q.size() : n;
    for (int i = 0; i < cyc; i++) begin
      logic [15:0] e;
      logic        m;
      e = exp_q.pop_front();
      m = mfc_q.pop_front();
      @(negedge Clk);
      check($sformatf("%s[c%0d]", tag, i), obs_v, e);
      bus.MFC = m;
      if (i == 0) begin
        bus.start = 1'b1; bus.op = rop; bus.op3_in = rop3;
      end else if (e[2]) begin
        bus.start = rbit(); bus.op = 2'($urandom_range(0, 3)); bus.op3_in = 6'($urandom);
      end else begin
        bus.start = rbit(); bus.op = 2'd3; bus.op3_in = 6'($urandom);
      end
    end
    exp_q.delete();
    mfc_q.delete();
  endtask

  initial begin
    logic [1:0] op;
    logic [5:0] op3;
    bus.start = 1'b0; bus.op = 2'd0; bus.op3_in = '0; bus.MFC = 1'b0;

    #1 RESET = 1'b1;
    #1 check("reset_state", obs_v, '0);
    @(negedge Clk);
    check("reset_hold", obs_v, '0);
    RESET = 1'b0;

    build(2'd0, 6'd1, 0, 0);   run(2'd0, 6'd1, -1, "load");
    build(2'd1, 6'd4, 0, 2);   run(2'd1, 6'd4, -1, "store_wait3");
    op3 = 6'($urandom);
    build(2'd2, op3, 0, 0);    run(2'd2, op3, -1, "swap");
    build(2'd2, 6'h3F, 2, 1);  run(2'd2, 6'h3F, -1, "swap_waits");

    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      check("rsv_op_idle", obs_v, '0);
      bus.start = 1'b1; bus.op = 2'd3; bus.op3_in = 6'($urandom); bus.MFC = rbit();
    end

    // Reset while waiting in the read request phase.
    build(2'd0, 6'h2A, 5, 0);
    run(2'd0, 6'h2A, 5, "pre_reset");
    #1 RESET = 1'b1;
    #1 check("reset_async", obs_v, '0);
    bus.start = 1'b0; bus.MFC = 1'b0;
    @(negedge Clk);
    check("reset_in_hold", obs_v, '0);
    RESET = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      check("post_reset_idle", obs_v, '0);
    end
    build(2'd0, 6'h15, 1, 0);  run(2'd0, 6'h15, -1, "load_after_reset");

    for (int t = 0; t < 24; t++) begin
      op  = 2'($urandom_range(0, 2));
      op3 = 6'($urandom);
      build(op, op3, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      run(op, op3, -1, $sformatf("rand%0d_op%0d", t, op));
    end

`ifdef MEM_TIMEOUT_EN
    push('0, 1'b0);
    push(v(1,0,0,0,6'h09,0,0,0,1,0,0), 1'b0);
    for (int j = 0; j < TMO; j++) push(v(0,0,1,1,6'h09,0,0,0,1,0,0), 1'b0);
    push(v(0,0,0,0,6'h00,0,0,0,1,0,1), rbit());
    push('0, rbit());
    run(2'd0, 6'h09, -1, "timeout_load");
    push('0, 1'b0);
    push(v(1,0,0,0,6'h22,0,0,0,1,0,0), 1'b0);
    push(v(0,1,0,0,6'h22,0,0,0,1,0,0), 1'b0);
    for (int j = 0; j < TMO; j++) push(v(0,0,0,1,6'h22,0,0,0,1,0,0), 1'b0);
    push(v(0,0,0,0,6'h00,0,0,0,1,0,1), rbit());
    push('0, rbit());
    run(2'd1, 6'h22, -1, "timeout_store");
`else
    push('0, 1'b0);
    push(v(1,0,0,0,6'h09,0,0,0,1,0,0), 1'b0);
    for (int j = 0; j < 30; j++) push(v(0,0,1,1,6'h09,0,0,0,1,0,0), 1'b0);
    run(2'd0, 6'h09, -1, "no_timeout_wait");
    #1 RESET = 1'b1;
    #1 check("reset_after_wait", obs_v, '0);
    bus.start = 1'b0; bus.MFC = 1'b0;
    @(negedge Clk);
    RESET = 1'b0;
`endif

    build(2'd1, 6'h11, 0, 0);  run(2'd1, 6'h11, -1, "final_store");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
